// File: rtl/convolution_sequencer.sv
// rtl/convolution_sequencer.sv - loads window/kernel elements, fires matrix accelerators, reduces per-channel results
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   s_valid/s_ready     load beat handshake; s_window/s_kernel carry one element per beat
//   multiplier_out      flat CHANNELS*KK*DATA_WIDTH bus of window elements (beat b at [b*DATA_WIDTH +: DATA_WIDTH])
//   multiplicand_out    flat bus of kernel elements, same packing
//   mStart              one-cycle all-ones start strobe, one bit per element
//   cReady/cSum         per-channel completion flag and 32-bit accumulation
//   m_valid/m_ready     result handshake; m_data is the cross-channel sum, m_error flags a timeout

module convolution_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int KERNEL_SIZE    = 3,
    parameter int CHANNELS       = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               s_valid,
    output logic                                               s_ready,
    input  logic [DATA_WIDTH-1:0]                              s_window,
    input  logic [DATA_WIDTH-1:0]                              s_kernel,
    output logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplier_out,
    output logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplicand_out,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]                 mStart,
    input  logic [CHANNELS-1:0]                                cReady,
    input  logic [CHANNELS*32-1:0]                             cSum,
    output logic                                               m_valid,
    input  logic                                               m_ready,
    output logic [31:0]                                        m_data,
    output logic                                               m_error
);

    localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NB = CHANNELS * KK;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        LOAD,
        FIRE,
        WAIT,
        REDUCE,
        OUTPUT
    } state_t;

    state_t              state;
    logic [BW-1:0]       beat;
    logic [CHANNELS-1:0] seen;
    logic [TW-1:0]       tcnt;
    logic [CW-1:0]       ridx;
    logic [31:0]         acc;
    logic [31:0]         ch_reg [CHANNELS];

    // Includes this cycle's captures so completion is recognised without an extra cycle.
    logic [CHANNELS-1:0] seen_next;
    assign seen_next = seen | cReady;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= LOAD;
            beat             <= '0;
            s_ready          <= 1'b1;
            mStart           <= '0;
            m_valid          <= 1'b0;
            m_data           <= '0;
            m_error          <= 1'b0;
            multiplier_out   <= '0;
            multiplicand_out <= '0;
            seen             <= '0;
            tcnt             <= '0;
            ridx             <= '0;
            acc              <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                ch_reg[n] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (s_valid && s_ready) begin
                        multiplier_out[beat*DATA_WIDTH +: DATA_WIDTH]   <= s_window;
                        multiplicand_out[beat*DATA_WIDTH +: DATA_WIDTH] <= s_kernel;
                        if (int'(beat) == NB - 1) begin
                            beat    <= '0;
                            s_ready <= 1'b0;
                            mStart  <= '1;
                            state   <= FIRE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end

                FIRE: begin
                    mStart <= '0;
                    seen   <= '0;
                    tcnt   <= '0;
                    state  <= WAIT;
                end

                WAIT: begin
                    // First cReady per channel wins; repeats are ignored via seen.
                    for (int n = 0; n < CHANNELS; n++) begin
                        if (cReady[n] && !seen[n]) begin
                            ch_reg[n] <= cSum[n*32 +: 32];
                        end
                    end
                    seen <= seen_next;
                    tcnt <= tcnt + 1'b1;
                    // Completion is checked first so it wins over a same-cycle expiry.
                    if (&seen_next) begin
                        acc   <= '0;
                        ridx  <= '0;
                        state <= REDUCE;
                    end else if (int'(tcnt) + 1 >= TIMEOUT_CYCLES) begin
                        m_valid <= 1'b1;
                        m_error <= 1'b1;
                        m_data  <= '0;
                        state   <= OUTPUT;
                    end
                end

                REDUCE: begin
                    // Channel registers shift down so the adder only ever reads ch_reg[0].
                    acc <= acc + ch_reg[0];
                    for (int n = 0; n < CHANNELS - 1; n++) begin
                        ch_reg[n] <= ch_reg[n+1];
                    end
                    if (int'(ridx) == CHANNELS - 1) begin
                        m_valid <= 1'b1;
                        m_error <= 1'b0;
                        m_data  <= acc + ch_reg[0];
                        state   <= OUTPUT;
                    end else begin
                        ridx <= ridx + 1'b1;
                    end
                end

                OUTPUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        beat    <= '0;
                        state   <= LOAD;
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_convolution_sequencer.sv
// tb/tb_convolution_sequencer.sv - self-checking bench for convolution_sequencer

module tb_convolution_sequencer;

    localparam int DW = 16;
    localparam int KS = 3;
    localparam int CH = 2;
    localparam int TO = 16;
    localparam int KK = KS * KS;
    localparam int NB = CH * KK;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [DW-1:0]       s_window = '0;
    logic [DW-1:0]       s_kernel = '0;
    logic [NB*DW-1:0]    multiplier_out;
    logic [NB*DW-1:0]    multiplicand_out;
    logic [KK-1:0]       mStart;
    logic [CH-1:0]       cReady = '0;
    logic [CH*32-1:0]    cSum = '0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [31:0]         m_data;
    logic                m_error;

    convolution_sequencer #(
        .DATA_WIDTH(DW),
        .KERNEL_SIZE(KS),
        .CHANNELS(CH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_window(s_window),
        .s_kernel(s_kernel),
        .multiplier_out(multiplier_out),
        .multiplicand_out(multiplicand_out),
        .mStart(mStart),
        .cReady(cReady),
        .cSum(cSum),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_error(m_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] win_v [NB];
    logic [DW-1:0] ker_v [NB];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_load(input bit gap, output int f);
        int idx;
        int budget;
        bit tog;
        idx = 0;
        budget = 0;
        tog = 1'b0;
        f = -1;
        while (idx < NB && budget < 100) begin
            @(negedge clk);
            tog = !tog;
            s_valid = gap ? tog : 1'b1;
            s_window = s_valid ? win_v[idx] : 16'($urandom);
            s_kernel = s_valid ? ker_v[idx] : 16'($urandom);
            cReady = '0;
            if (s_valid && s_ready) begin
                idx++;
                if (idx == NB) f = cyc + 1;
            end
            budget++;
        end
        checks++;
        if (idx != NB) $display("FAIL load_beats: accepted %0d required %0d", idx, NB);
        else passes++;
    endtask

    task automatic run_txn(input string name, input bit gap, input int r0, input int r1, input int rp0,
                           input logic [31:0] sum0, input logic [31:0] sum1, input int hold);
        int f, ev, cmax, rel, bad;
        bit done, exp_e, got_valid;
        logic [31:0] exp_d;
        logic [KK-1:0] exp_ms;
        do_load(gap, f);
        if (f < 0) return;
        done = (r0 >= 1) && (r1 >= 1) && (r0 <= TO) && (r1 <= TO);
        cmax = (r0 > r1) ? r0 : r1;
        ev = done ? f + cmax + 1 + CH : f + TO + 1;
        exp_d = done ? sum0 + sum1 : 32'd0;
        exp_e = !done;
        got_valid = 1'b0;
        for (int k = 0; k < 200 && !got_valid; k++) begin
            @(negedge clk);
            rel = cyc - f;
            s_valid = 1'($urandom_range(0, 1));
            s_window = 16'($urandom);
            s_kernel = 16'($urandom);
            cReady[0] = (rel == 0) || (rel == r0) || (rel == rp0);
            cReady[1] = (rel == 0) || (rel == r1);
            cSum[31:0] = (rel == 0 || rel == rp0) ? ~sum0 : sum0;
            cSum[63:32] = (rel == 0) ? ~sum1 : sum1;
            if (rel == 0) begin
                bad = -1;
                for (int i = 0; i < NB; i++)
                    if (multiplier_out[i*DW +: DW] !== win_v[i] || multiplicand_out[i*DW +: DW] !== ker_v[i]) bad = i;
                checks++;
                if (bad >= 0) $display("FAIL %s bus_pack: beat %0d got %h/%h required %h/%h", name, bad,
                                       multiplier_out[bad*DW +: DW], multiplicand_out[bad*DW +: DW], win_v[bad], ker_v[bad]);
                else passes++;
            end
            if (rel == 0) exp_ms = '1;
            else exp_ms = '0;
            checks++;
            if (mStart !== exp_ms) $display("FAIL %s mstart: rel %0d got %h required %h", name, rel, mStart, exp_ms);
            else passes++;
            checks++;
            if (s_ready !== 1'b0) $display("FAIL %s s_ready_busy: rel %0d got %b required 0", name, rel, s_ready);
            else passes++;
            if (m_valid === 1'b1 || cyc == ev) begin
                got_valid = 1'b1;
                checks++;
                if (cyc != ev || m_valid !== 1'b1)
                    $display("FAIL %s latency: m_valid=%b at cycle %0d required 1 at cycle %0d", name, m_valid, cyc, ev);
                else passes++;
                checks++;
                if (m_data !== exp_d) $display("FAIL %s m_data: got %h required %h", name, m_data, exp_d);
                else passes++;
                checks++;
                if (m_error !== exp_e) $display("FAIL %s m_error: got %b required %b", name, m_error, exp_e);
                else passes++;
            end
        end
        checks++;
        if (!got_valid) $display("FAIL %s result_timeout: no m_valid within budget required at cycle %0d", name, ev);
        else passes++;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            m_ready = 1'b0;
            s_valid = 1'($urandom_range(0, 1));
            s_window = 16'($urandom);
            s_kernel = 16'($urandom);
            cReady = 2'($urandom);
            cSum = {$urandom, $urandom};
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d || m_error !== exp_e || s_ready !== 1'b0 || mStart !== '0)
                $display("FAIL %s hold: cycle %0d valid=%b data=%h err=%b s_ready=%b mStart=%h required 1/%h/%b/0/0",
                         name, h, m_valid, m_data, m_error, s_ready, mStart, exp_d, exp_e);
            else passes++;
        end
        @(negedge clk);
        m_ready = 1'b1;
        s_valid = 1'b0;
        cReady = '0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== exp_d) $display("FAIL %s pre_handshake: valid=%b data=%h required 1/%h", name, m_valid, m_data, exp_d);
        else passes++;
        bad = -1;
        for (int i = 0; i < NB; i++)
            if (multiplier_out[i*DW +: DW] !== win_v[i] || multiplicand_out[i*DW +: DW] !== ker_v[i]) bad = i;
        checks++;
        if (bad >= 0) $display("FAIL %s bus_stable: beat %0d got %h required %h", name, bad, multiplier_out[bad*DW +: DW], win_v[bad]);
        else passes++;
        @(negedge clk);
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) $display("FAIL %s post_handshake: valid=%b s_ready=%b required 0/1", name, m_valid, s_ready);
        else passes++;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < NB; i++) begin
            case (mode)
                0: begin win_v[i] = 16'd2; ker_v[i] = 16'd3; end
                1: begin win_v[i] = 16'd1; ker_v[i] = 16'd1; end
                default: begin win_v[i] = 16'($urandom); ker_v[i] = 16'($urandom); end
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || mStart !== '0 || m_data !== '0 || m_error !== 1'b0 ||
            multiplier_out !== '0 || multiplicand_out !== '0)
            $display("FAIL reset_state: s_ready=%b m_valid=%b mStart=%h m_data=%h m_error=%b required 1/0/0/0/0 and zero buses",
                     s_ready, m_valid, mStart, m_data, m_error);
        else passes++;
    endtask

    task automatic test_basic();
        fill(0);
        run_txn("basic", 1'b0, 5, 5, -1, 32'd54, 32'd54, 0);
    endtask

    task automatic test_wrap();
        fill(2);
        run_txn("wrap", 1'b0, 3, 7, 9, 32'hFFFF_FFFF, 32'd2, 0);
    endtask

    task automatic test_timeout();
        fill(2);
        run_txn("timeout", 1'b0, -1, -1, -1, 32'd5, 32'd6, 1);
        fill(2);
        run_txn("timeout_one_seen", 1'b0, 16, 17, -1, 32'd5, 32'd6, 0);
        fill(2);
        run_txn("expiry_tie", 1'b0, 16, 16, -1, 32'd7, 32'd8, 0);
    endtask

    task automatic test_backpressure();
        fill(2);
        run_txn("backpressure", 1'b0, 2, 4, -1, $urandom, $urandom, 10);
    endtask

    task automatic test_gap_load();
        fill(2);
        run_txn("gap_load", 1'b1, 1, 1, -1, $urandom, $urandom, 0);
    endtask

    task automatic test_reset_mid_wait();
        int f;
        fill(2);
        do_load(1'b0, f);
        repeat (5) begin
            @(negedge clk);
            s_valid = 1'b0;
            cReady = '0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            cReady = 2'($urandom) | 2'b01;
            cSum = {$urandom, $urandom};
            if (i > 0) begin
                checks++;
                if (m_valid !== 1'b0 || mStart !== '0 || m_data !== '0 || m_error !== 1'b0 ||
                    multiplier_out !== '0 || multiplicand_out !== '0)
                    $display("FAIL mid_wait_reset: m_valid=%b mStart=%h m_data=%h m_error=%b required 0/0/0/0 and zero buses",
                             m_valid, mStart, m_data, m_error);
                else passes++;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cReady = '0;
        checks++;
        if (s_ready !== 1'b1) $display("FAIL mid_wait_release: s_ready got %b required 1", s_ready);
        else passes++;
        fill(1);
        run_txn("after_reset", 1'b0, 3, 4, -1, 32'd9, 32'd0, 0);
    endtask

    task automatic test_random();
        int r0, r1;
        for (int t = 0; t < 8; t++) begin
            fill(2);
            r0 = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 18));
            r1 = int'($urandom_range(1, 18));
            run_txn("random", 1'($urandom_range(0, 1)), r0, r1, -1, $urandom, $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_timeout();
        test_backpressure();
        test_gap_load();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
